hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised pipeline hazard and control unit for the out-of-order core. It sits between issue (IS) and the execute/writeback stages and generates enable, stall and flush controls for fetch, the IF/IS register, the ROB, NUM_RS reservation stations and NUM_WB writeback latches. It allows up to MAX_BR unresolved branches in flight. It arbitrates the single memory port between the commit store, the load buffer and fetch, using starvation protection. On a misprediction it runs a flush-recovery state machine that holds issue for FLUSH_HOLD cycles.

## Interface
- NUM_RS, 2: number of reservation-station classes. Class 0 is ALU and class 1 is LD/ST by convention.
- NUM_WB, 3: number of writeback latches (one per functional unit).
- MAX_BR, 1: maximum number of issued, unresolved branches. MAX_BR ≥ 1.
- STARVE_LIMIT, 4: number of consecutive fetch denials caused by the load buffer before fetch gets priority over it. STARVE_LIMIT ≥ 1.
- FLUSH_HOLD, 1: number of cycles issue is held after a mispredict. FLUSH_HOLD ≥ 0.
- Derived: RS_SEL_W = max(1, clog2(NUM_RS)); BR_W = clog2(MAX_BR+1); ST_W = clog2(STARVE_LIMIT+1); FH_W = max(1, clog2(FLUSH_HOLD+1)).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rob_full  in  1  ROB cannot accept an entry.
- rs_full  in  NUM_RS  per-class RS full.
- is_valid_inst  in  1  IS holds a valid instruction.
- is_rs_sel  in  RS_SEL_W  target RS class of the IS instruction. Values ≥ NUM_RS are treated as not issuable.
- is_branch  in  1  IS instruction is a branch.
- br_resolve  in  1  a branch leaves execute this cycle. The producer already qualifies it with its own stall.
- br_mispredict  in  1  the resolving branch was mispredicted. Ignored unless br_resolve=1.
- wb_valid, wb_written  in  NUM_WB each  per-latch valid / consumed-this-cycle.
- commit_wr_mem  in  1  commit store needs the memory port this cycle.
- lb_rd_req  in  1  load buffer requests the memory port.
- if_enable  out  1  fetch PC/fetch register advances.
- if_is_enable  out  1  IF/IS register loads.
- if_is_flush  out  1  IF/IS register is invalidated.
- rob_enable  out  1  ROB allocates.
- rs_enable  out  NUM_RS  one-hot RS allocate.
- wb_enable  out  NUM_WB  latch may load.
- exec_stall  out  NUM_WB  FU feeding latch i must hold.
- lb_mem_grant, if_mem_grant  out  1 each  memory-port grants.
- br_pending_cnt  out  BR_W  registered count of in-flight branches.
- flush_busy  out  1  FSM is in state FLUSH.

## Operation
- Writeback: wb_enable[i] = ~wb_valid[i] | wb_written[i]. exec_stall[i] = ~wb_enable[i].
- Issue stall: is_stall = rob_full | rs_full[is_rs_sel] | (is_rs_sel ≥ NUM_RS) | (br_pending_cnt == MAX_BR) | flush_busy. The count check uses the registered count only; a resolve in the same cycle does not unblock issue.
- Issue outputs: issue = ~is_stall & is_valid_inst & ~mispredict_now, where mispredict_now = br_resolve & br_mispredict.
  - rob_enable = issue.
  - rs_enable[k] = issue & (is_rs_sel == k).
  - if_is_enable = ~is_stall.
- Branch counter update, in priority order:
  1. mispredict_now → 0.
  2. Otherwise, +1 if (issue & is_branch) and −1 if br_resolve. If both occur, the count is unchanged.
  3. The count saturates at 0 and MAX_BR. Never wraps.
- Memory arbiter:
  - A commit store always wins.
  - Otherwise, the load buffer beats fetch unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - if_mem_grant = ~commit_wr_mem & ~(lb_rd_req & starve_cnt < STARVE_LIMIT).
  - lb_mem_grant = lb_rd_req & ~commit_wr_mem & ~if_mem_grant_by_starve.
  - starve_cnt increments (saturating) when lb_mem_grant=1 and fetch was denied. It clears on if_mem_grant. It holds when commit_wr_mem denies fetch.
- Fetch:
  - if_enable = if_mem_grant & (~is_stall | flush_busy | mispredict_now).
  - if_is_flush = mispredict_now | (~if_mem_grant & ~is_stall). This inserts a bubble when fetch loses the port.
- Flush FSM, states RUN and FLUSH:
  - RUN→FLUSH on mispredict_now when FLUSH_HOLD > 0. The hold counter loads FLUSH_HOLD−1.
  - In FLUSH, the counter decrements. The FSM returns to RUN in the cycle after the counter reaches 0.
  - A mispredict_now in FLUSH reloads the counter.
  - With FLUSH_HOLD = 0 the FSM stays in RUN.

## Timing
- Reset values: br_pending_cnt=0, FSM=RUN, hold counter=0, starve_cnt=0, flush_busy=0. All other outputs are combinational functions of these values and the current inputs.
  - Example: with all inputs 0, if_enable=1, if_is_enable=1, wb_enable=all 1s, and every other output is 0.
- Reset asserted mid-flush or mid-starvation returns all state to its reset value at the next edge.
- Latency: every enable, stall, flush and grant output is combinational, with zero cycles from its inputs. The effect of br_pending_cnt and flush_busy appears one cycle after the causing event.
- With MAX_BR=1 and FLUSH_HOLD=0 the block behaves as a single-branch blocking hazard unit.

## Test plan
- Reset then idle: inputs 0 → if_enable=1, if_is_enable=1, rob_enable=0, cnt=0, flush_busy=0.
- MAX_BR=2: issue two branches on consecutive cycles → cnt 1 then 2. The third valid instruction gets rob_enable=0. A correct br_resolve brings cnt to 1, and issue resumes on the next cycle.
- Branch issue and correct resolve in the same cycle at cnt=1 → cnt stays 1. A mispredict with a simultaneous branch issue → cnt=0, rob_enable=0, if_is_flush=1.
- FLUSH_HOLD=2: mispredict → flush_busy=1 for 2 cycles with rs_enable=0 and if_enable=1. A second mispredict in the first FLUSH cycle extends the hold to 2 cycles from that point.
- STARVE_LIMIT=4, lb_rd_req held at 1 → lb granted 4 cycles, fetch granted on the 5th, then lb again. commit_wr_mem=1 → both grants 0 and lb's exec is blocked.
- wb_valid=1, wb_written=0 on latch 2 → exec_stall[2]=1 while the other latches are unaffected. Setting wb_written=1 → exec_stall[2]=0 in the same cycle.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: issue/branch/flush hazard control with starvation-protected memory-port arbitration
module hazard_ctrl_unit #(
  parameter int NUM_RS = 2,
  parameter int NUM_WB = 3,
  parameter int MAX_BR = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int FLUSH_HOLD = 1,
  localparam int RS_SEL_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
  localparam int BR_W = $clog2(MAX_BR + 1),
  localparam int ST_W = $clog2(STARVE_LIMIT + 1),
  localparam int FH_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rob_full,
  input  logic [NUM_RS-1:0]   rs_full,
  input  logic                is_valid_inst,
  input  logic [RS_SEL_W-1:0] is_rs_sel,
  input  logic                is_branch,
  input  logic                br_resolve,
  input  logic                br_mispredict,
  input  logic [NUM_WB-1:0]   wb_valid,
  input  logic [NUM_WB-1:0]   wb_written,
  input  logic                commit_wr_mem,
  input  logic                lb_rd_req,
  output logic                if_enable,
  output logic                if_is_enable,
  output logic                if_is_flush,
  output logic                rob_enable,
  output logic [NUM_RS-1:0]   rs_enable,
  output logic [NUM_WB-1:0]   wb_enable,
  output logic [NUM_WB-1:0]   exec_stall,
  output logic                lb_mem_grant,
  output logic                if_mem_grant,
  output logic [BR_W-1:0]     br_pending_cnt,
  output logic                flush_busy
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [FH_W-1:0] HOLD_LOAD = FH_W'(FLUSH_HOLD > 0 ? FLUSH_HOLD - 1 : 0);
  state_t state, state_nxt;
  logic [FH_W-1:0] hold, hold_nxt;
  logic [ST_W-1:0] starve_cnt, starve_nxt;
  logic [BR_W-1:0] br_nxt;
  logic [NUM_RS-1:0] rs_hit;
  logic mispredict_now, is_stall, issue, br_full, starve_hit, inc, dec, mp_go;
  for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
    assign rs_hit[k] = is_rs_sel == RS_SEL_W'(k);
  end
  assign wb_enable = ~wb_valid | wb_written;
  assign exec_stall = ~wb_enable;
  assign mispredict_now = br_resolve & br_mispredict;
  assign br_full = br_pending_cnt == BR_W'(MAX_BR);
  assign is_stall = rob_full | |(rs_hit & rs_full) | ~|rs_hit | br_full | flush_busy;
  assign issue = ~is_stall & is_valid_inst & ~mispredict_now;
  assign rob_enable = issue;
  assign rs_enable = {NUM_RS{issue}} & rs_hit;
  assign if_is_enable = ~is_stall;
  assign starve_hit = starve_cnt == ST_W'(STARVE_LIMIT);
  assign if_mem_grant = ~commit_wr_mem & ~(lb_rd_req & ~starve_hit);
  assign lb_mem_grant = lb_rd_req & ~commit_wr_mem & ~starve_hit;
  assign if_enable = if_mem_grant & (~is_stall | flush_busy | mispredict_now);
  assign if_is_flush = mispredict_now | (~if_mem_grant & ~is_stall);
  assign inc = issue & is_branch;
  assign dec = br_resolve;
  assign mp_go = mispredict_now & (FLUSH_HOLD > 0);
  always_comb begin
    br_nxt = mispredict_now ? '0 :
             (inc & ~dec & ~br_full) ? br_pending_cnt + BR_W'(1) :
             (dec & ~inc & br_pending_cnt != '0) ? br_pending_cnt - BR_W'(1) : br_pending_cnt;
    starve_nxt = if_mem_grant ? '0 : (lb_mem_grant & ~starve_hit) ? starve_cnt + ST_W'(1) : starve_cnt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      hold <= '0;
      br_pending_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      hold <= hold_nxt;
      br_pending_cnt <= br_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  always_comb begin
    state_nxt = mp_go ? FLUSH : (state == FLUSH && hold == '0) ? RUN : state;
    hold_nxt = mp_go ? HOLD_LOAD : (state == FLUSH && hold != '0) ? hold - FH_W'(1) : hold;
  end
  always_comb begin
    flush_busy = state == FLUSH;
  end
endmodule
